fpu_div_iter: RTL and testbench
===============================

# fpu_div_iter

Parametrised, iterative IEEE-754-style floating-point divider; successor to the single-shot FPU divide coprocessor. It adds a valid/ready handshake on both sides and returns to idle after every operation, so it can be issued back-to-back. It also adds configurable quotient bits per cycle, four rounding modes, and full special-operand handling (NaN, infinity, zero, divide-by-zero). It sits beside the other FPU coprocessors and drives the shared condition-code and status-flag buses.

## Interface
- FP_T, fp16_t, packed {sign, exp, frac} operand/result type
- FRACW, 10, fraction width
- EXPW, 5, exponent width
- BIAS, 15, exponent bias
- BPC, 1, quotient bits retired per CALC cycle (1 or 2)
- clock  input  1  sole clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- inValid  input  1  operands and mode are valid
- inReady  output  1  block can accept; high only in IDLE
- fpuIn1  input  FP_T  dividend
- fpuIn2  input  FP_T  divisor
- roundMode  input  2  00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
- outValid  output  1  result valid; held until accepted
- outReady  input  1  consumer accepts the result
- fpuOut  output  FP_T  quotient
- condCodes  output  4  {Z, C, N, V}
- divFlags  output  5  {invalid, divByZero, overflow, underflow, inexact}

## Operation
- States: IDLE, CALC, ROUND, HOLD.
- IDLE: inReady=1. On inValid, capture the operands, roundMode, the XOR of the sign bits, and the unbiased exponent difference (signed, EXPW+2 bits).
  - Special operand next state is ROUND.
  - Otherwise next state is CALC.
- Special cases, in priority order:
  - NaN operand, 0/0, or inf/inf → quiet NaN (exp all ones, frac MSB set, sign 0), invalid.
  - x/0 with finite nonzero x → signed infinity, divByZero.
  - inf/finite → signed infinity, no flags.
  - 0/nonzero or finite/inf → signed zero, no flags.
- CALC: radix-2 restoring division of the normalised significands, each {1, frac}.
  - N = FRACW+3 quotient bits; ITER = ceil(N/BPC) cycles.
  - Iteration counter runs 0..ITER-1.
  - Sticky = (final remainder != 0).
- ROUND:
  - If the quotient MSB is 0, shift left 1 and decrement the exponent.
  - Add BIAS to the exponent.
  - Denormalise if the biased exponent is <= 0.
  - Round with guard/round/sticky per the captured roundMode.
  - Renormalise on rounding carry.
  - Overflow: biased exponent >= 2^EXPW-1 after rounding. Result is infinity (RNE, or directed toward the overflow side) or max finite (RTZ, or directed away); flags overflow and inexact.
  - Underflow: result tiny and inexact.
  - Inexact: any discarded bit is set.
- HOLD: outValid=1; fpuOut, condCodes and divFlags are stable. On outReady go to IDLE.
- Outputs are registered in ROUND. They hold their value in IDLE until the next ROUND overwrites them.
- condCodes:
  - Z = (exp==0 && frac==0)
  - C = 0
  - N = fpuOut.sign
  - V = overflow
- Reset value of every output is 0, except inReady=1.

## Timing
- Accept edge t0 (IDLE, inValid=1).
- Normal path: CALC for cycles t0..t0+ITER-1, ROUND at t0+ITER, outValid high from t0+ITER+1.
  - fp16, BPC=1: ITER=13, outValid 14 cycles after accept.
  - fp16, BPC=2: ITER=7, outValid 8 cycles after accept.
- Special path: ROUND at t0, outValid from t0+1.
- outValid && outReady at edge t → IDLE at t+1, so inReady rises at t+1. There is no same-cycle re-accept; minimum issue interval is latency+1.
- outReady low: HOLD persists indefinitely and outputs do not change.
- inValid outside IDLE is ignored; operands are not re-sampled.
- reset asserted in any state → IDLE immediately. Any partial result is discarded and outputs are zeroed.

## Configuration
- FPU_DIV_DENORM_EN defined:
  - Subnormal inputs are normalised at capture using a leading-zero count, which adjusts the exponent.
  - Subnormal results are produced with gradual underflow.
- Not defined:
  - Subnormal inputs are treated as signed zero, with no flag.
  - Results with biased exponent <= 0 flush to signed zero, with underflow and inexact set.

## Test plan
- 0x3C00/0x4000, RNE, BPC=1 → fpuOut 0x3800, divFlags 0, outValid exactly 14 cycles after accept; inReady high the cycle after outReady.
- 0x3C00/0x4200 → RNE 0x3555 inexact; RTZ 0x3555; RUP 0x3556; RDN 0x3555; each with inexact set.
- Specials:
  - 0x3C00/0x0000 → 0x7C00, divByZero.
  - 0x0000/0x0000 → 0x7E00, invalid.
  - 0xFC00/0x4000 → 0xFC00, no flags.
  - Each special case returns outValid one cycle after accept.
- 0x7BFF/0x3800 → RNE 0x7C00 with overflow and inexact, V=1; RTZ 0x7BFF with the same flags.
- 0x0400/0x4000:
  - With FPU_DIV_DENORM_EN → 0x0200, flags 0.
  - Without it → 0x0000, underflow and inexact, Z=1.
- Backpressure and reset:
  - Hold outReady=0 for 20 cycles → outputs constant, inReady=0.
  - Assert reset mid-CALC → next cycle inReady=1 and all outputs are 0.
  - A following 0x4000/0x4000 → 0x3C00.

Source files
------------

// File: rtl/fpu_div_iter.sv
// fpu_div_iter - iterative floating-point divider (radix-2 restoring).
//
// Divides i_fpuIn1 by i_fpuIn2 with IEEE-754 style rounding and handling of
// NaN, infinity, zero and divide-by-zero. Operands are accepted with a
// valid/ready handshake, and the result is offered with one. The block
// returns to IDLE after every operation.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid is high and
// ready is low. o_inReady is high only in IDLE. o_outValid is high only in
// HOLD, and the result is held there until i_outReady.
//
// Ports:
//   i_clock, i_reset     clock; asynchronous active-high reset
//   i_inValid/o_inReady  operand handshake
//   i_fpuIn1, i_fpuIn2   dividend, divisor {sign, exp, frac}
//   i_roundMode          00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   o_outValid/i_outReady result handshake
//   o_fpuOut             quotient
//   o_condCodes          {Z, C, N, V}
//   o_divFlags           {invalid, divByZero, overflow, underflow, inexact}
//   o_dbgState           current FSM state (IDLE=0, CALC=1, ROUND=2, HOLD=3)
//
// Build option FPU_DIV_DENORM_EN: when defined, subnormal operands are
// normalised at capture and subnormal results use gradual underflow. When
// it is not defined, subnormal operands are read as zero and tiny results
// flush to signed zero.
module fpu_div_iter #(
  parameter int FRACW = 10,
  parameter int EXPW  = 5,
  parameter int BIAS  = 15,
  parameter int BPC   = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_inValid,
  output logic                  o_inReady,
  input  logic [EXPW+FRACW:0]   i_fpuIn1,
  input  logic [EXPW+FRACW:0]   i_fpuIn2,
  input  logic [1:0]            i_roundMode,
  output logic                  o_outValid,
  input  logic                  i_outReady,
  output logic [EXPW+FRACW:0]   o_fpuOut,
  output logic [3:0]            o_condCodes,
  output logic [4:0]            o_divFlags,
  output logic [1:0]            o_dbgState
);
  localparam int W    = EXPW + FRACW + 1;
  localparam int N    = FRACW + 3;            // hidden + frac + guard + round
  localparam int ITER = (N + BPC - 1) / BPC;
  localparam int QW   = ITER * BPC;           // quotient bits actually produced
  localparam int MW   = FRACW + 1;            // significand {1, frac}
  localparam int RW   = FRACW + 3;            // partial remainder
  localparam int DW   = EXPW + 2;             // signed exponent difference
  localparam int XW   = EXPW + 5;             // exponent field incl. overflow headroom
  localparam int CW   = $clog2(ITER + 1);

  typedef struct packed {
    logic             sign;
    logic [EXPW-1:0]  exp;
    logic [FRACW-1:0] frac;
  } fp_t;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND, S_HOLD} state_t;

  state_t r_state, w_state_nx;
  logic                  r_sign, r_spec;
  logic [1:0]            r_rm;
  logic signed [DW-1:0]  r_exp;
  logic [W-1:0]          r_spec_res, r_out;
  logic [4:0]            r_spec_flags, r_flags;
  logic [3:0]            r_cc;
  logic [RW-1:0]         r_rem;
  logic [MW-1:0]         r_mb;
  logic [QW-1:0]         r_quot;
  logic [CW-1:0]         r_cnt;

`ifdef FPU_DIV_DENORM_EN
  function automatic int f_lzc(input logic [FRACW-1:0] f);
    int n;
    n = FRACW;
    for (int i = 0; i < FRACW; i++) if (f[i]) n = FRACW - 1 - i;
    return n;
  endfunction
`endif

  // ---------------- operand decode and special cases ----------------
  fp_t w_a, w_b;
  assign w_a = i_fpuIn1;
  assign w_b = i_fpuIn2;

  logic w_a_expz, w_a_fracz, w_a_nan, w_a_inf, w_a_zero;
  logic w_b_expz, w_b_fracz, w_b_nan, w_b_inf, w_b_zero;
  logic w_sign, w_spec;
  logic [W-1:0] w_spec_res;
  logic [4:0] w_spec_flags;
  logic [MW-1:0] w_ma, w_mb;
  logic signed [DW-1:0] w_ea, w_eb, w_dexp;

  assign w_a_expz  = ~|w_a.exp;
  assign w_a_fracz = ~|w_a.frac;
  assign w_a_nan   = (&w_a.exp) & ~w_a_fracz;
  assign w_a_inf   = (&w_a.exp) & w_a_fracz;
  assign w_b_expz  = ~|w_b.exp;
  assign w_b_fracz = ~|w_b.frac;
  assign w_b_nan   = (&w_b.exp) & ~w_b_fracz;
  assign w_b_inf   = (&w_b.exp) & w_b_fracz;
`ifdef FPU_DIV_DENORM_EN
  assign w_a_zero  = w_a_expz & w_a_fracz;
  assign w_b_zero  = w_b_expz & w_b_fracz;
`else
  // Subnormal operands read as zero.
  assign w_a_zero  = w_a_expz;
  assign w_b_zero  = w_b_expz;
`endif
  assign w_sign    = w_a.sign ^ w_b.sign;

  always_comb begin
    w_spec       = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = 5'b00000;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res   = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};
      w_spec_flags = 5'b10000;
    end else if (w_b_zero && !w_a_inf) begin
      w_spec_res   = {w_sign, {EXPW{1'b1}}, {FRACW{1'b0}}};
      w_spec_flags = 5'b01000;
    end else if (w_a_inf) begin
      w_spec_res   = {w_sign, {EXPW{1'b1}}, {FRACW{1'b0}}};
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res   = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_spec       = 1'b0;
    end
  end

  // Significands and effective exponents. A normalised subnormal gets
  // biased exponent -lzc so that exp differences stay exact.
  always_comb begin
    w_ma = {1'b1, w_a.frac};
    w_mb = {1'b1, w_b.frac};
    w_ea = $signed({2'b00, w_a.exp});
    w_eb = $signed({2'b00, w_b.exp});
`ifdef FPU_DIV_DENORM_EN
    if (w_a_expz && !w_a_fracz) begin
      w_ma = {1'b1, w_a.frac << (f_lzc(w_a.frac) + 1)};
      w_ea = -DW'(f_lzc(w_a.frac));
    end
    if (w_b_expz && !w_b_fracz) begin
      w_mb = {1'b1, w_b.frac << (f_lzc(w_b.frac) + 1)};
      w_eb = -DW'(f_lzc(w_b.frac));
    end
`endif
    w_dexp = w_ea - w_eb;
  end

  // ---------------- restoring division step(s) ----------------
  logic [RW-1:0] w_rem_nx;
  logic [QW-1:0] w_quot_nx;
  always_comb begin
    w_rem_nx  = r_rem;
    w_quot_nx = r_quot;
    for (int k = 0; k < BPC; k++) begin
      if (w_rem_nx >= RW'(r_mb)) begin
        w_rem_nx  = w_rem_nx - RW'(r_mb);
        w_quot_nx = {w_quot_nx[QW-2:0], 1'b1};
      end else begin
        w_quot_nx = {w_quot_nx[QW-2:0], 1'b0};
      end
      w_rem_nx = w_rem_nx << 1;
    end
  end

  // ---------------- normalise / denormalise / round ----------------
  logic [N-1:0] w_m0, w_m1, w_m2;
  logic [2*N-1:0] w_wide;
  logic w_st0, w_st1, w_tiny, w_lsb, w_g, w_rs, w_inexact, w_inc, w_ovf, w_to_inf;
  int w_bei, w_sh, w_eb1;
  logic [XW+FRACW-1:0] w_sum;
  logic [W-1:0] w_res;
  logic [4:0] w_flags;

  always_comb begin
    w_m0  = r_quot[QW-1 -: N];
    // Quotient bits beyond N (BPC not dividing N) only feed sticky.
    w_st0 = (|r_rem) | (|(r_quot << N));
    w_bei = int'(r_exp) + BIAS;
    w_m1  = w_m0;
    if (!w_m0[N-1]) begin
      w_m1  = w_m0 << 1;
      w_bei = w_bei - 1;
    end
    w_tiny = (w_bei <= 0);
    w_sh   = w_tiny ? (1 - w_bei) : 0;
    if (w_sh > N) w_sh = N;
    w_wide = {w_m1, {N{1'b0}}} >> w_sh;
    w_m2   = w_wide[2*N-1:N];
    w_st1  = w_st0 | (|w_wide[N-1:0]);
    w_lsb  = w_m2[2];
    w_g    = w_m2[1];
    w_rs   = w_m2[0] | w_st1;
    w_inexact = w_g | w_rs;
    case (r_rm)
      2'b00:   w_inc = w_g & (w_rs | w_lsb);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = r_sign & w_inexact;
      default: w_inc = ~r_sign & w_inexact;
    endcase
    w_to_inf = (r_rm == 2'b00) || (r_rm == 2'b11 && !r_sign) || (r_rm == 2'b10 && r_sign);
    // exp-1 plus {hidden, frac}: hidden=1 restores exp for normals, hidden=0
    // leaves field 0 for subnormals, and a rounding carry ripples into exp.
    w_eb1 = w_tiny ? 0 : w_bei - 1;
    w_sum = {XW'(w_eb1), {FRACW{1'b0}}} + (XW+FRACW)'(w_m2[N-1:2]) + (XW+FRACW)'(w_inc);
    w_ovf = !w_tiny && (w_sum[XW+FRACW-1:FRACW] >= XW'((1 << EXPW) - 1));
    w_res   = {r_sign, w_sum[EXPW+FRACW-1:0]};
    w_flags = {3'b000, w_tiny & w_inexact, w_inexact};
    if (w_ovf) begin
      w_flags = 5'b00101;
      if (w_to_inf) w_res = {r_sign, {EXPW{1'b1}}, {FRACW{1'b0}}};
      else          w_res = {r_sign, {(EXPW-1){1'b1}}, 1'b0, {FRACW{1'b1}}};
    end
`ifndef FPU_DIV_DENORM_EN
    else if (w_tiny) begin
      w_res   = {r_sign, {(W-1){1'b0}}};
      w_flags = 5'b00011;
    end
`endif
    if (r_spec) begin
      w_res   = r_spec_res;
      w_flags = r_spec_flags;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    o_inReady  = 1'b0;
    o_outValid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_inReady = 1'b1;
        if (i_inValid) w_state_nx = w_spec ? S_ROUND : S_CALC;
      end
      S_CALC:  if (r_cnt == CW'(ITER - 1)) w_state_nx = S_ROUND;
      S_ROUND: w_state_nx = S_HOLD;
      default: begin
        o_outValid = 1'b1;
        if (i_outReady) w_state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sign <= 1'b0; r_spec <= 1'b0; r_rm <= 2'b00; r_exp <= '0;
      r_spec_res <= '0; r_spec_flags <= '0;
      r_rem <= '0; r_mb <= '0; r_quot <= '0; r_cnt <= '0;
      r_out <= '0; r_flags <= '0; r_cc <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_inValid) begin
          r_sign       <= w_sign;
          r_rm         <= i_roundMode;
          r_exp        <= w_dexp;
          r_spec       <= w_spec;
          r_spec_res   <= w_spec_res;
          r_spec_flags <= w_spec_flags;
          r_rem        <= RW'(w_ma);
          r_mb         <= w_mb;
          r_quot       <= '0;
          r_cnt        <= '0;
        end
        S_CALC: begin
          r_rem  <= w_rem_nx;
          r_quot <= w_quot_nx;
          r_cnt  <= r_cnt + CW'(1);
        end
        S_ROUND: begin
          r_out   <= w_res;
          r_flags <= w_flags;
          r_cc    <= {~|w_res[W-2:0], 1'b0, w_res[W-1], w_flags[2]};
        end
        default: ;
      endcase
    end
  end

  assign o_fpuOut    = r_out;
  assign o_divFlags  = r_flags;
  assign o_condCodes = r_cc;
  assign o_dbgState  = r_state;
endmodule

// File: tb/tb_fpu_div_iter.sv
// Directed testbench for fpu_div_iter (fp16, BPC configurable below).
module tb_fpu_div_iter;
  localparam int BPC     = 1;
  localparam int EXP_LAT = (13 + BPC - 1) / BPC + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  rm = 2'b00;
  logic [15:0] in1 = '0, in2 = '0;
  logic        in_ready, out_valid;
  logic [15:0] fout;
  logic [3:0]  cc;
  logic [4:0]  fl;
  logic [1:0]  dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_div_iter #(.FRACW(10), .EXPW(5), .BIAS(15), .BPC(BPC)) dut (
    .i_clock(clk), .i_reset(rst), .i_inValid(in_valid), .o_inReady(in_ready),
    .i_fpuIn1(in1), .i_fpuIn2(in2), .i_roundMode(rm),
    .o_outValid(out_valid), .i_outReady(out_ready), .o_fpuOut(fout),
    .o_condCodes(cc), .o_divFlags(fl), .o_dbgState(dbg)
  );

  // Issue one operation and wait (bounded) for outValid; result is left in HOLD.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                        output logic [15:0] res, output logic [3:0] c,
                        output logic [4:0] f, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: inReady=%b required 1", in_ready);
    end
    in1 = a; in2 = b; rm = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = 16'h7FFF; in2 = 16'h0000;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      n_vec++; n_err++;
      $display("FAIL valid_timeout: outValid=%b required 1", out_valid);
    end
    res = fout; c = cc; f = fl;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid, fout, cc, fl} !== {1'b1, 1'b0, 16'h0, 4'h0, 5'h0}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b vld=%b out=%h cc=%b fl=%b required 1 0 0000 0000 00000",
               in_ready, out_valid, fout, cc, fl);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (dbg !== 2'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle: got state=%0d rdy=%b required 0 1", dbg, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] a_t[4], b_t[4], e_t[4];
    logic [3:0]  c_t[4];
    logic [15:0] r; logic [3:0] c; logic [4:0] f; int lat;
    a_t = '{16'h3C00, 16'h4600, 16'hC000, 16'h4000};
    b_t = '{16'h4000, 16'h4200, 16'h4000, 16'h4000};
    e_t = '{16'h3800, 16'h4000, 16'hBC00, 16'h3C00};
    c_t = '{4'b0000, 4'b0000, 4'b0010, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      run_op(a_t[i], b_t[i], 2'b00, r, c, f, lat);
      n_vec++;
      if (r !== e_t[i] || f !== 5'b0 || c !== c_t[i]) begin
        n_err++;
        $display("FAIL basic_%0d: got %h fl=%b cc=%b required %h 00000 %b", i, r, f, c, e_t[i], c_t[i]);
      end
      n_vec++;
      if (lat !== EXP_LAT) begin
        n_err++;
        $display("FAIL basic_latency_%0d: got %0d required %0d", i, lat, EXP_LAT);
      end
      release_out();
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL basic_release_%0d: got rdy=%b vld=%b required 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] e_pos[4], e_neg[4];
    logic [15:0] r; logic [3:0] c; logic [4:0] f; int lat;
    // 1/3 = 1.0101010101|01.. x 2^-2 ; -1/3 mirrors with directed modes swapped.
    e_pos = '{16'h3555, 16'h3555, 16'h3555, 16'h3556};
    e_neg = '{16'hB555, 16'hB555, 16'hB556, 16'hB555};
    for (int m = 0; m < 4; m++) begin
      run_op(16'h3C00, 16'h4200, 2'(m), r, c, f, lat);
      n_vec++;
      if (r !== e_pos[m] || f !== 5'b00001) begin
        n_err++;
        $display("FAIL round_pos_rm%0d: got %h fl=%b required %h 00001", m, r, f, e_pos[m]);
      end
      release_out();
      run_op(16'hBC00, 16'h4200, 2'(m), r, c, f, lat);
      n_vec++;
      if (r !== e_neg[m] || f !== 5'b00001 || c !== 4'b0010) begin
        n_err++;
        $display("FAIL round_neg_rm%0d: got %h fl=%b cc=%b required %h 00001 0010", m, r, f, c, e_neg[m]);
      end
      release_out();
    end
  endtask

  task automatic test_specials();
    logic [15:0] a_t[4], b_t[4], e_t[4];
    logic [4:0]  f_t[4];
    logic [3:0]  c_t[4];
    logic [15:0] r; logic [3:0] c; logic [4:0] f; int lat;
    a_t = '{16'h3C00, 16'h0000, 16'hFC00, 16'h7E01};
    b_t = '{16'h0000, 16'h0000, 16'h4000, 16'h3C00};
    e_t = '{16'h7C00, 16'h7E00, 16'hFC00, 16'h7E00};
    f_t = '{5'b01000, 5'b10000, 5'b00000, 5'b10000};
    c_t = '{4'b0000, 4'b0000, 4'b0010, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      run_op(a_t[i], b_t[i], 2'b00, r, c, f, lat);
      n_vec++;
      if (r !== e_t[i] || f !== f_t[i] || c !== c_t[i]) begin
        n_err++;
        $display("FAIL special_%0d: got %h fl=%b cc=%b required %h %b %b", i, r, f, c, e_t[i], f_t[i], c_t[i]);
      end
      n_vec++;
      if (lat !== 1) begin
        n_err++;
        $display("FAIL special_latency_%0d: got %0d required 1", i, lat);
      end
      release_out();
    end
  endtask

  task automatic test_overflow();
    logic [15:0] r; logic [3:0] c; logic [4:0] f; int lat;
    run_op(16'h7BFF, 16'h3800, 2'b00, r, c, f, lat);
    n_vec++;
    if (r !== 16'h7C00 || f !== 5'b00101 || c !== 4'b0001) begin
      n_err++;
      $display("FAIL overflow_rne: got %h fl=%b cc=%b required 7c00 00101 0001", r, f, c);
    end
    release_out();
    run_op(16'h7BFF, 16'h3800, 2'b01, r, c, f, lat);
    n_vec++;
    if (r !== 16'h7BFF || f !== 5'b00101 || c !== 4'b0001) begin
      n_err++;
      $display("FAIL overflow_rtz: got %h fl=%b cc=%b required 7bff 00101 0001", r, f, c);
    end
    release_out();
  endtask

  task automatic test_underflow();
    logic [15:0] r; logic [3:0] c; logic [4:0] f; int lat;
    logic [15:0] e_r; logic [4:0] e_f; logic [3:0] e_c;
`ifdef FPU_DIV_DENORM_EN
    e_r = 16'h0200; e_f = 5'b00000; e_c = 4'b0000;
`else
    e_r = 16'h0000; e_f = 5'b00011; e_c = 4'b1000;
`endif
    run_op(16'h0400, 16'h4000, 2'b00, r, c, f, lat);
    n_vec++;
    if (r !== e_r || f !== e_f || c !== e_c) begin
      n_err++;
      $display("FAIL underflow: got %h fl=%b cc=%b required %h %b %b", r, f, c, e_r, e_f, e_c);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [15:0] r; logic [3:0] c; logic [4:0] f; int lat;
    run_op(16'h4000, 16'h4000, 2'b00, r, c, f, lat);
    // New operands offered during HOLD must be ignored.
    in1 = 16'h0000; in2 = 16'h0000; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, fout, cc, fl} !== {1'b1, 1'b0, 16'h3C00, 4'h0, 5'h0}) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: got vld=%b rdy=%b out=%h cc=%b fl=%b required 1 0 3c00 0000 00000",
                 i, out_valid, in_ready, fout, cc, fl);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_vec++;
    if (in_ready !== 1'b1 || fout !== 16'h3C00) begin
      n_err++;
      $display("FAIL hold_release: got rdy=%b out=%h required 1 3c00", in_ready, fout);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; logic [3:0] c; logic [4:0] f; int lat;
    in1 = 16'h3C00; in2 = 16'h4200; rm = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_vec++;
    if (dbg !== 2'd1) begin
      n_err++;
      $display("FAIL mid_calc_state: got %0d required 1", dbg);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, out_valid, fout, cc, fl} !== {1'b1, 1'b0, 16'h0, 4'h0, 5'h0}) begin
      n_err++;
      $display("FAIL reset_mid: got rdy=%b vld=%b out=%h cc=%b fl=%b required 1 0 0000 0000 00000",
               in_ready, out_valid, fout, cc, fl);
    end
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    n_vec++;
    if (out_valid !== 1'b0 || dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_discard: got vld=%b state=%0d required 0 0", out_valid, dbg);
    end
    run_op(16'h4000, 16'h4000, 2'b00, r, c, f, lat);
    n_vec++;
    if (r !== 16'h3C00 || f !== 5'b0 || lat !== EXP_LAT) begin
      n_err++;
      $display("FAIL after_reset: got %h fl=%b lat=%0d required 3c00 00000 %0d", r, f, lat, EXP_LAT);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [15:0] r; logic [3:0] c; logic [4:0] f; int lat;
    run_op(16'h3C00, 16'h4000, 2'b00, r, c, f, lat);
    release_out();
    run_op(16'h4600, 16'h3C00, 2'b01, r, c, f, lat);
    n_vec++;
    if (r !== 16'h4600 || f !== 5'b0 || lat !== EXP_LAT) begin
      n_err++;
      $display("FAIL back_to_back: got %h fl=%b lat=%0d required 4600 00000 %0d", r, f, lat, EXP_LAT);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_overflow();
    test_underflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
